// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit:
// state enum, opcodes, ALUOp and ALUControl codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTER  = 4'd6,
    S_EXECUTEI  = 4'd7,
    S_ALUWB     = 4'd8,
    S_BEQ       = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode from ALUOp and the instruction funct fields.
// Op5 separates R-type sub from I-type addi when Funct7b5 is set.
module alu_decoder
  import mc_pkg::*;
(
  input  aluop_t     ALUOp,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Op5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (Funct3)
          3'b000:  ALUControl = ({Op5, Funct7b5} == 2'b11)
                              ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V main control FSM with memory-latency wait counter.
// Define JALR_EN to add the JALR / JALR_LINK states.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] State
);

  localparam logic [1:0] WAIT_LAST = 2'(MEM_RD_LAT);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic       last;
  logic       pc_update;
  logic       branch;
  aluop_t     alu_op;

  assign last  = (cnt == WAIT_LAST);
  assign State = state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_FETCH;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = 2'd0;
    case (state)
      S_FETCH: begin
        if (last) state_nxt = S_DECODE;
        else      cnt_nxt   = cnt + 2'd1;
      end
      S_DECODE: begin
        case (Op)
          OP_LOAD,
          OP_STORE:  state_nxt = S_MEMADR;
          OP_RTYPE:  state_nxt = S_EXECUTER;
          OP_ITYPE:  state_nxt = S_EXECUTEI;
          OP_BRANCH: state_nxt = S_BEQ;
          OP_JAL:    state_nxt = S_JAL;
`ifdef JALR_EN
          OP_JALR:   state_nxt = S_JALR;
`endif
          default:   state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_nxt = Op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (last) state_nxt = S_MEMWB;
        else      cnt_nxt   = cnt + 2'd1;
      end
      S_MEMWB,
      S_MEMWRITE,
      S_BEQ,
      S_ALUWB:    state_nxt = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      state_nxt = S_ALUWB;
`ifdef JALR_EN
      S_JALR:      state_nxt = S_JALR_LINK;
      S_JALR_LINK: state_nxt = S_ALUWB;
`endif
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = last;
        pc_update = last;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
`ifdef JALR_EN
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_JALR_LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);

  always_comb begin
    ImmSrc = 2'b00;
    unique case (1'b1)
      (Op == OP_STORE):  ImmSrc = 2'b01;
      (Op == OP_BRANCH): ImmSrc = 2'b10;
      (Op == OP_JAL):    ImmSrc = 2'b11;
      (Op == OP_ITYPE),
      (Op == OP_LOAD),
      (Op == OP_JALR):   ImmSrc = 2'b00;
      default:           ImmSrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_dec (
    .ALUOp      (alu_op),
    .Funct3     (Funct3),
    .Funct7b5   (Funct7b5),
    .Op5        (Op[5]),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, reset corner
// sequences and random instruction streams against a path model.
module tb_mc_control_fsm;

  localparam int L = 1;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic       Clk, Reset;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic       Funct7b5, Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  mc_control_fsm #(.MEM_RD_LAT(L)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct3(Funct3),
    .Funct7b5(Funct7b5), .Zero(Zero), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .State(State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alc;
  } outs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         n;
    int         seq [8];
    logic [2:0] alc;
  } vec_t;

  typedef struct {
    logic [3:0] s;
    bit         last;
  } pe_t;

  int   checks = 0;
  int   failures = 0;
  pe_t  path [$];
  vec_t vecs [13];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic outs_t dut_outs();
    return {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
            ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
  endfunction

  // Expected outputs for one state, straight from the per-state rules.
  function automatic outs_t model(logic [3:0] s, bit last,
      logic [6:0] op, logic [2:0] f3, logic f7, logic z);
    outs_t o;
    int aop;
    bit pcu, br;
    o = '0; aop = 0; pcu = 0; br = 0;
    o.st = s;
    case (s)
      0:  begin o.sb = 2; o.rs = 2; o.irw = last; pcu = last; end
      1:  begin o.sa = 1; o.sb = 1; end
      2:  begin o.sa = 2; o.sb = 1; end
      3:  o.adr = 1;
      4:  begin o.rs = 1; o.rw = 1; end
      5:  begin o.adr = 1; o.mw = 1; end
      6:  begin o.sa = 2; aop = 2; end
      7:  begin o.sa = 2; o.sb = 1; aop = 2; end
      8:  o.rw = 1;
      9:  begin o.sa = 2; aop = 1; br = 1; end
      10: begin o.sa = 1; o.sb = 2; pcu = 1; end
      11: begin o.sa = 2; o.sb = 1; o.rs = 2; pcu = 1; end
      12: begin o.sa = 1; o.sb = 2; end
      default: ;
    endcase
    o.pcw = pcu | (br & z);
    if (op == SW)       o.imm = 1;
    else if (op == BEQ) o.imm = 2;
    else if (op == JAL) o.imm = 3;
    if (aop == 1) o.alc = 3'b001;
    else if (aop == 2) begin
      case (f3)
        3'b000: o.alc = (op[5] && f7) ? 3'b001 : 3'b000;
        3'b010: o.alc = 3'b101;
        3'b110: o.alc = 3'b011;
        3'b111: o.alc = 3'b010;
        default: o.alc = 3'b000;
      endcase
    end
    return o;
  endfunction

  task automatic push_n(int s, int cnt);
    for (int i = 0; i < cnt; i++) begin
      pe_t e;
      e.s = 4'(s);
      e.last = (i == cnt - 1);
      path.push_back(e);
    end
  endtask

  // Whole-instruction state walk derived from the opcode.
  task automatic build_path(logic [6:0] op);
    path.delete();
    push_n(0, L + 1);
    push_n(1, 1);
    if (op == LW) begin
      push_n(2, 1); push_n(3, L + 1); push_n(4, 1);
    end else if (op == SW) begin
      push_n(2, 1); push_n(5, 1);
    end else if (op == RT) begin
      push_n(6, 1); push_n(8, 1);
    end else if (op == IT) begin
      push_n(7, 1); push_n(8, 1);
    end else if (op == BEQ) begin
      push_n(9, 1);
    end else if (op == JAL) begin
      push_n(10, 1); push_n(8, 1);
`ifdef JALR_EN
    end else if (op == JALR) begin
      push_n(11, 1); push_n(12, 1); push_n(8, 1);
`endif
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
  endtask

  task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic f7);
    Op = op; Funct3 = f3; Funct7b5 = f7;
    build_path(op);
    foreach (path[i]) begin
      Zero = 1'($urandom);
      @(negedge Clk);
      chk($sformatf("rand_op%0h_step%0d", op, i), 32'(dut_outs()),
          32'(model(path[i].s, path[i].last, op, f3, f7, Zero)));
      cyc();
    end
  endtask

  initial begin
    logic [6:0] ops [9];
    Reset = 1'b1; Op = BAD; Funct3 = 3'd0; Funct7b5 = 1'b0; Zero = 1'b0;

    vecs[0]  = '{"lw",   LW,  3'd2, 1'b0, 1'b0, 7,
                 '{0,0,1,2,3,3,4,0}, 3'b000};
    vecs[1]  = '{"sw",   SW,  3'd2, 1'b0, 1'b0, 5,
                 '{0,0,1,2,5,0,0,0}, 3'b000};
    vecs[2]  = '{"add",  RT,  3'd0, 1'b0, 1'b0, 5,
                 '{0,0,1,6,8,0,0,0}, 3'b000};
    vecs[3]  = '{"sub",  RT,  3'd0, 1'b1, 1'b0, 5,
                 '{0,0,1,6,8,0,0,0}, 3'b001};
    vecs[4]  = '{"addi", IT,  3'd0, 1'b1, 1'b0, 5,
                 '{0,0,1,7,8,0,0,0}, 3'b000};
    vecs[5]  = '{"slt",  RT,  3'd2, 1'b0, 1'b0, 5,
                 '{0,0,1,6,8,0,0,0}, 3'b101};
    vecs[6]  = '{"or",   RT,  3'd6, 1'b0, 1'b0, 5,
                 '{0,0,1,6,8,0,0,0}, 3'b011};
    vecs[7]  = '{"and",  RT,  3'd7, 1'b0, 1'b1, 5,
                 '{0,0,1,6,8,0,0,0}, 3'b010};
    vecs[8]  = '{"beq_t", BEQ, 3'd0, 1'b0, 1'b1, 4,
                 '{0,0,1,9,0,0,0,0}, 3'b001};
    vecs[9]  = '{"beq_n", BEQ, 3'd0, 1'b0, 1'b0, 4,
                 '{0,0,1,9,0,0,0,0}, 3'b001};
    vecs[10] = '{"jal",  JAL, 3'd0, 1'b0, 1'b0, 5,
                 '{0,0,1,10,8,0,0,0}, 3'b000};
    vecs[11] = '{"bad",  BAD, 3'd0, 1'b0, 1'b0, 3,
                 '{0,0,1,0,0,0,0,0}, 3'b000};
`ifdef JALR_EN
    vecs[12] = '{"jalr", JALR, 3'd0, 1'b0, 1'b0, 6,
                 '{0,0,1,11,12,8,0,0}, 3'b000};
`else
    vecs[12] = '{"jalr", JALR, 3'd0, 1'b0, 1'b0, 3,
                 '{0,0,1,0,0,0,0,0}, 3'b000};
`endif

    // reset held for two cycles
    cyc();
    @(negedge Clk);
    chk("rst_c1", 32'(dut_outs()), 32'(model(0, 0, BAD, 0, 0, 0)));
    cyc();
    @(negedge Clk);
    chk("rst_c2", 32'(dut_outs()), 32'(model(0, 0, BAD, 0, 0, 0)));
    cyc();
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst1_state", 32'(State), 32'd0);
    chk("post_rst1_irw", 32'(IRWrite), 32'd0);
    cyc();
    @(negedge Clk);
    chk("post_rst2_irw", 32'(IRWrite), 32'd1);
    chk("post_rst2_pcw", 32'(PCWrite), 32'd1);
    cyc();
    @(negedge Clk);
    chk("bad_decode", 32'(State), 32'd1);
    cyc();

    foreach (vecs[v]) begin
      int run, mwc, rwc;
      Op = vecs[v].op; Funct3 = vecs[v].f3;
      Funct7b5 = vecs[v].f7; Zero = vecs[v].z;
      run = 0; mwc = 0; rwc = 0;
      for (int k = 0; k < vecs[v].n; k++) begin
        int es;
        bit last;
        @(negedge Clk);
        es = vecs[v].seq[k];
        run = (k > 0 && vecs[v].seq[k-1] == es) ? run + 1 : 0;
        last = (es == 0 || es == 3) && run == L;
        chk($sformatf("%s_state%0d", vecs[v].name, k),
            32'(State), 32'(es));
        chk($sformatf("%s_outs%0d", vecs[v].name, k),
            32'(dut_outs()),
            32'(model(4'(es), last, vecs[v].op, vecs[v].f3,
                      vecs[v].f7, vecs[v].z)));
        if (k == L + 2)
          chk($sformatf("%s_aluctl", vecs[v].name),
              32'(ALUControl), 32'(vecs[v].alc));
        mwc += int'(MemWrite);
        if (RegWrite && State != 4 && State != 8) rwc++;
        cyc();
      end
      chk($sformatf("%s_memwrite_cnt", vecs[v].name), 32'(mwc),
          (vecs[v].op == SW) ? 32'd1 : 32'd0);
      chk($sformatf("%s_stray_regwrite", vecs[v].name),
          32'(rwc), 32'd0);
    end

    // reset in the middle of the fetch wait clears the counter
    Op = BAD;
    @(negedge Clk);
    chk("mid_fetch_state", 32'(State), 32'd0);
    cyc();
    @(negedge Clk);
    chk("mid_fetch_irw", 32'(IRWrite), 32'd1);
    pulse_reset();
    @(negedge Clk);
    chk("fetch_rst_irw", 32'(IRWrite), 32'd0);
    chk("fetch_rst_state", 32'(State), 32'd0);
    pulse_reset();

    // reset while in MEMWRITE
    Op = SW;
    for (int k = 0; k < L + 3; k++) cyc();
    @(negedge Clk);
    chk("sw_in_memwrite", 32'(State), 32'd5);
    chk("sw_mw_high", 32'(MemWrite), 32'd1);
    pulse_reset();
    @(negedge Clk);
    chk("sw_rst_state", 32'(State), 32'd0);
    chk("sw_rst_outs", 32'(dut_outs()), 32'(model(0, 0, SW, 0, 0, Zero)));
    pulse_reset();

    ops = '{LW, SW, RT, IT, BEQ, JAL, JALR, BAD, BAD};
    for (int i = 0; i < 300; i++) begin
      int sel;
      logic [6:0] op;
      sel = int'($urandom_range(0, 8));
      op = (sel == 8) ? 7'($urandom) : ops[sel];
      run_instr(op, 3'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_RD_LAT, default 1, memory read latency in cycles; legal values 0..3.
REQ-002 Clk  in  1  single clock; all state changes on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Op  in  7  instruction opcode from the instruction register.
REQ-005 Funct3  in  3, Funct7b5  in  1, Zero  in  1: ALU decode fields and ALU zero flag.
REQ-006 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each: datapath enables and selects.
REQ-007 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each; ALUControl  out  3.
REQ-008 State  out  4: current state encoding, for debug.

Function
REQ-009 States SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, JALR=11, JALR_LINK=12.
REQ-010 A wait counter SHALL hold FETCH and MEMREAD for MEM_RD_LAT+1 cycles total, clearing on exit.
REQ-011 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite and PCUpdate asserted on the last FETCH cycle only.
REQ-012 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next state by Op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL, 1100111->JALR (REQ-024), any other->FETCH with no writes.
REQ-013 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; Op[5]=0->MEMREAD, else->MEMWRITE.
REQ-014 MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB after the wait; MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
REQ-015 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 for exactly one cycle -> FETCH.
REQ-016 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both -> ALUWB.
REQ-017 ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-018 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH; JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
REQ-019 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinational within the state.
REQ-020 Any output not listed for a state SHALL be 0.
REQ-021 ImmSrc from Op: I-type/load/jalr=00, store=01, branch=10, jal=11, else 00.
REQ-022 ALUControl: ALUOp 00->000 add; 01->001 sub; 10 by Funct3: 000->001 if {Op[5],Funct7b5}=11 else 000, 010->101 slt, 110->011 or, 111->010 and, others->000.

Reset
REQ-023 Reset SHALL force State=FETCH and wait counter=0 on the next edge, overriding any transition including mid-MEMWRITE; all outputs SHALL then take FETCH values with IRWrite/PCUpdate gated by the counter.

Configuration
REQ-024 JALR_EN defined: JALR (ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCUpdate=1) -> JALR_LINK (ALUSrcA=01, ALUSrcB=10, ALUOp=00) -> ALUWB; JALR_EN undefined: Op 1100111 is illegal, DECODE -> FETCH, states 11/12 unreachable.

Structure
REQ-025 State enum, opcode constants, ALUOp and ALUControl encodings SHALL live in a shared package mc_pkg.
REQ-026 ALU decode (REQ-022) SHALL be sub-module alu_decoder; ImmSrc decode stays inline.

Verification
REQ-027 Reset held 2 cycles, MEM_RD_LAT=1 -> State=0, IRWrite=0 first cycle, IRWrite=1 and PCWrite=1 second cycle.
REQ-028 lw (Op=0000011), MEM_RD_LAT=1 -> sequence 0,0,1,2,3,3,4,0; RegWrite=1 only in state 4.
REQ-029 sw (Op=0100011) -> 0,0,1,2,5,0; MemWrite=1 exactly one cycle; Reset asserted in state 5 -> State=0 next cycle.
REQ-030 beq Zero=1 -> PCWrite=1 in BEQ, ALUControl=001; Zero=0 -> PCWrite=0.
REQ-031 R-type sub (Funct3=000, Funct7b5=1) -> ALUControl=001 in EXECUTER; Op=1111111 -> DECODE->FETCH, no RegWrite/MemWrite.
REQ-032 jalr with JALR_EN -> 1,11,12,8,0; without -> 1,0.
